// File: rtl/dsram_axi_arb.sv
// dsram_axi_arb: merges SRAM-style fetch and load/store ports onto a
// single-outstanding AXI master (single-beat INCR, len=0).
module dsram_axi_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] axi_rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        own_q, own_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        iok_q, iok_d;
  logic        dok_q, dok_d;
  logic        aw_fin, w_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      own_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      iok_q     <= 1'b0;
      dok_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      own_q     <= own_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      iok_q     <= iok_d;
      dok_q     <= dok_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    own_d        = own_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    iok_d        = 1'b0;
    dok_d        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    // A channel counts as finished once its handshake has been seen.
    aw_fin       = aw_done_q | awready;
    w_fin        = w_done_q | wready;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (data_req) begin
          data_addr_ok = 1'b1;
          addr_d       = data_addr;
          size_d       = {1'b0, data_size};
          wdata_d      = data_wdata;
          wstrb_d      = data_wstrb;
          own_d        = 1'b1;
          state_d      = data_wr ? WR_REQ : RD_ADDR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          addr_d       = inst_addr;
          size_d       = 3'd2;
          wdata_d      = '0;
          wstrb_d      = '0;
          own_d        = 1'b0;
          state_d      = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = axi_rdata;
          iok_d   = ~own_q;
          dok_d   = own_q;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          dok_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign araddr       = addr_q;
  assign arsize       = size_q;
  assign awaddr       = addr_q;
  assign awsize       = size_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign rdata        = rdata_q;
  assign inst_data_ok = iok_q;
  assign data_data_ok = dok_q;

endmodule

// File: tb/tb_dsram_axi_arb.sv
// tb_dsram_axi_arb: directed + randomized scoreboard bench with an
// AXI slave model and a word-memory reference model.
module tb_dsram_axi_arb;

  logic        clk, rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] rdata;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] axi_rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  dsram_axi_arb dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .axi_rdata(axi_rdata), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid),
    .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Reference memory: untouched words hold a pattern derived from the address.
  function automatic logic [31:0] init_word(logic [31:0] a);
    if (a[31:2] == 30'h2FF00000) return 32'h3C1D0000;
    return {a[17:2], ~a[17:2]} ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] d,
                                        logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  logic [31:0] slv_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] slv_rd(logic [31:0] a);
    return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
  endfunction

  typedef struct {
    logic        own;
    logic        wr;
    logic [31:0] rd;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [3:0]  ws;
  } ax_t;

  resp_t resp_q[$];
  ax_t   ax_q[$];
  resp_t r;
  ax_t   t;
  logic [31:0] last_rd;

  // Slave model state and wait knobs.
  bit   rand_mode = 0;
  int   k_ar = 0, k_aw = 0, k_w = 0, k_r = 0, k_b = 0;
  int   ar_w = 0, aw_w = 0, w_w = 0, r_w = 0, b_w = 0;
  int   arcnt = 0, awcnt = 0, wcnt = 0, rcnt = 0, bcnt = 0;
  logic rd_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] rd_addr = 0, aw_a = 0, w_d = 0;
  logic [3:0]  w_s = 0;
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0;
  logic        p_wv = 0, p_wrdy = 0;
  logic [31:0] p_ara = 0, p_awa = 0, p_wd = 0;

  initial begin
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; bvalid = 0; axi_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      arready = arvalid && (arcnt >= (rand_mode ? ar_w : k_ar));
      awready = awvalid && (awcnt >= (rand_mode ? aw_w : k_aw));
      wready  = wvalid && (wcnt >= (rand_mode ? w_w : k_w));
      rvalid  = rd_pend && (rcnt >= (rand_mode ? r_w : k_r));
      axi_rdata = rvalid ? slv_rd(rd_addr) : 32'h0;
      bvalid  = b_pend && (bcnt >= (rand_mode ? b_w : k_b));
    end
  end

  // Monitor: scoreboard, protocol checks and slave bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      resp_q.delete();
      ax_q.delete();
      last_rd = 0;
      rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      arcnt = 0; awcnt = 0; wcnt = 0; rcnt = 0; bcnt = 0;
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (inst_data_ok || data_data_ok) begin
        chk1("ok_onehot", inst_data_ok & data_data_ok, 1'b0);
        if (resp_q.size() == 0) begin
          chk1("ok_spurious", 1'b1, 1'b0 & data_data_ok);
        end else begin
          r = resp_q.pop_front();
          chk1("ok_owner", data_data_ok, r.own);
          if (r.wr) begin
            chk("st_rdata_keep", rdata, last_rd);
          end else begin
            chk("ld_rdata", rdata, r.rd);
            last_rd = r.rd;
          end
        end
      end
      if (inst_addr_ok || data_addr_ok) begin
        chk1("acc_onehot", inst_addr_ok & data_addr_ok, 1'b0);
        chk("acc_single", resp_q.size(), 0);
        if (data_addr_ok) begin
          chk1("dacc_req", data_req, 1'b1);
          t.wr = data_wr; t.addr = data_addr;
          t.size = {1'b0, data_size};
          t.wd = data_wdata; t.ws = data_wstrb;
          r.own = 1; r.wr = data_wr; r.rd = ref_rd(data_addr);
          if (data_wr)
            ref_mem[data_addr[31:2]] =
              merge(ref_rd(data_addr), data_wdata, data_wstrb);
        end else begin
          chk1("prio", data_req, 1'b0);
          chk1("iacc_req", inst_req, 1'b1);
          t.wr = 0; t.addr = inst_addr; t.size = 3'd2;
          t.wd = 0; t.ws = 0;
          r.own = 0; r.wr = 0; r.rd = ref_rd(inst_addr);
        end
        resp_q.push_back(r);
        ax_q.push_back(t);
      end
      if (p_arv && !p_arr) begin
        chk1("ar_hold_v", arvalid, 1'b1);
        chk("ar_hold_a", araddr, p_ara);
      end
      if (p_awv && !p_awr) begin
        chk1("aw_hold_v", awvalid, 1'b1);
        chk("aw_hold_a", awaddr, p_awa);
      end
      if (p_wv && !p_wrdy) begin
        chk1("w_hold_v", wvalid, 1'b1);
        chk("w_hold_d", wdata, p_wd);
      end
      if (rvalid && rready) begin
        rd_pend = 0;
        r_w = $urandom_range(0, 3);
      end else if (rd_pend && !rvalid) begin
        rcnt++;
      end
      if (arvalid && arready) begin
        if (ax_q.size() == 0) begin
          chk1("ar_unexpected", arvalid, 1'b0);
        end else begin
          t = ax_q.pop_front();
          chk1("ar_is_read", t.wr, 1'b0);
          chk("araddr", araddr, t.addr);
          chk("arsize", 32'(arsize), 32'(t.size));
        end
        rd_pend = 1; rd_addr = araddr; rcnt = 0;
        arcnt = 0; ar_w = $urandom_range(0, 3);
      end else if (arvalid) begin
        arcnt++;
      end
      if (bvalid && bready) begin
        b_pend = 0;
        b_w = $urandom_range(0, 3);
      end else if (b_pend && !bvalid) begin
        bcnt++;
      end
      if (awvalid && awready) begin
        if (ax_q.size() == 0) begin
          chk1("aw_unexpected", awvalid, 1'b0);
        end else begin
          chk1("aw_is_write", ax_q[0].wr, 1'b1);
          chk("awaddr", awaddr, ax_q[0].addr);
          chk("awsize", 32'(awsize), 32'(ax_q[0].size));
        end
        aw_got = 1; aw_a = awaddr;
        awcnt = 0; aw_w = $urandom_range(0, 3);
      end else if (awvalid) begin
        awcnt++;
      end
      if (wvalid && wready) begin
        if (ax_q.size() == 0) begin
          chk1("w_unexpected", wvalid, 1'b0);
        end else begin
          chk("wdata", wdata, ax_q[0].wd);
          chk("wstrb", 32'(wstrb), 32'(ax_q[0].ws));
        end
        w_got = 1; w_d = wdata; w_s = wstrb;
        wcnt = 0; w_w = $urandom_range(0, 3);
      end else if (wvalid) begin
        wcnt++;
      end
      if (aw_got && w_got) begin
        slv_mem[aw_a[31:2]] = merge(slv_rd(aw_a), w_d, w_s);
        if (ax_q.size() != 0) t = ax_q.pop_front();
        aw_got = 0; w_got = 0;
        b_pend = 1; bcnt = 0;
      end
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wrdy = wready; p_wd = wdata;
    end
  end

  task automatic wait_idle(string nm);
    int n = 0;
    while (resp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, resp_q.size(), 0);
  endtask

  task automatic set_data(logic wr, logic [1:0] sz, logic [31:0] a,
                          logic [31:0] wd, logic [3:0] ws);
    data_req = 1; data_wr = wr; data_size = sz;
    data_addr = a; data_wdata = wd; data_wstrb = ws;
  endtask

  task automatic inst_drv(int n);
    for (int i = 0; i < n; i++) begin
      int c = 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      inst_req = 1;
      inst_addr = 32'hBFC00000 + 32'($urandom_range(0, 63) * 4);
      do begin
        @(negedge clk);
        c++;
      end while (!inst_addr_ok && c < 300);
      chk1("inst_accept", inst_addr_ok, 1'b1);
      @(posedge clk);
      #1;
      inst_req = 0;
    end
  endtask

  task automatic data_drv(int n);
    for (int i = 0; i < n; i++) begin
      int c = 0;
      int sz, off;
      logic [3:0] ws;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sz = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3) :
            (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      ws = (sz == 0) ? (4'b0001 << off) :
           (sz == 1) ? (4'b0011 << off) : 4'b1111;
      set_data(1'($urandom_range(0, 1)), 2'(sz),
               32'h80001000 + 32'($urandom_range(0, 15) * 4 + off),
               32'($urandom), ws);
      do begin
        @(negedge clk);
        c++;
      end while (!data_addr_ok && c < 300);
      chk1("data_accept", data_addr_ok, 1'b1);
      @(posedge clk);
      #1;
      data_req = 0;
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1; inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; data_wstrb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_iok", inst_data_ok, 1'b0);
    chk1("rst_dok", data_data_ok, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    // Zero-wait fetch latency.
    @(posedge clk);
    #1;
    inst_req = 1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk1("f_addr_ok_c0", inst_addr_ok, 1'b1);
    @(posedge clk);
    #1;
    inst_req = 0;
    @(negedge clk);
    chk1("f_arvalid_c1", arvalid, 1'b1);
    chk("f_araddr_c1", araddr, 32'hBFC00000);
    chk("f_arsize_c1", 32'(arsize), 32'd2);
    @(negedge clk);
    chk1("f_dok_c2", inst_data_ok, 1'b0);
    @(negedge clk);
    chk1("f_dok_c3", inst_data_ok, 1'b1);
    chk("f_rdata_c3", rdata, 32'h3C1D0000);
    wait_idle("f_idle");

    // Simultaneous requests: data first.
    @(posedge clk);
    #1;
    set_data(0, 2'd2, 32'h80001000, 32'h0, 4'h0);
    inst_req = 1; inst_addr = 32'hBFC00004;
    @(negedge clk);
    chk1("pri_data_acc", data_addr_ok, 1'b1);
    chk1("pri_inst_wait", inst_addr_ok, 1'b0);
    @(posedge clk);
    #1;
    data_req = 0;
    n = 0; seen = 0;
    do begin
      @(negedge clk);
      if (data_data_ok) seen = 1;
      n++;
    end while (!inst_addr_ok && n < 50);
    chk1("pri_inst_acc", inst_addr_ok, 1'b1);
    chk1("pri_order", seen, 1'b1);
    @(posedge clk);
    #1;
    inst_req = 0;
    wait_idle("pri_idle");

    // Store with AW accepted two cycles before W.
    k_aw = 0; k_w = 2;
    @(posedge clk);
    #1;
    set_data(1, 2'd2, 32'h80001010, 32'h12345678, 4'hF);
    @(negedge clk);
    chk1("st_acc", data_addr_ok, 1'b1);
    @(posedge clk);
    #1;
    data_req = 0;
    @(negedge clk);
    chk1("st_c1_awv", awvalid, 1'b1);
    chk1("st_c1_wv", wvalid, 1'b1);
    @(negedge clk);
    chk1("st_c2_awv", awvalid, 1'b0);
    chk1("st_c2_wv", wvalid, 1'b1);
    @(negedge clk);
    chk1("st_c3_wv", wvalid, 1'b1);
    chk1("st_c3_dok", data_data_ok, 1'b0);
    @(negedge clk);
    chk1("st_c4_bready", bready, 1'b1);
    chk1("st_c4_dok", data_data_ok, 1'b0);
    @(negedge clk);
    chk1("st_c5_dok", data_data_ok, 1'b1);
    wait_idle("st_idle");
    k_w = 0;

    // Byte load keeps the unaligned address.
    @(posedge clk);
    #1;
    set_data(0, 2'd0, 32'h80001003, 32'h0, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    data_req = 0;
    @(negedge clk);
    chk("lb_araddr", araddr, 32'h80001003);
    chk("lb_arsize", 32'(arsize), 32'd0);
    wait_idle("lb_idle");

    // arready stalled five cycles with a fetch pending.
    k_ar = 5;
    @(posedge clk);
    #1;
    set_data(0, 2'd2, 32'h80001008, 32'h0, 4'h0);
    inst_req = 1; inst_addr = 32'hBFC00008;
    @(negedge clk);
    @(posedge clk);
    #1;
    data_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("stall_arvalid", arvalid, 1'b1);
      chk("stall_araddr", araddr, 32'h80001008);
      chk1("stall_no_iacc", inst_addr_ok, 1'b0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_addr_ok && n < 50);
    chk1("stall_inst_acc", inst_addr_ok, 1'b1);
    @(posedge clk);
    #1;
    inst_req = 0;
    wait_idle("stall_idle");
    k_ar = 0;

    // Reset while waiting in RD_DATA.
    k_r = 3;
    @(posedge clk);
    #1;
    set_data(0, 2'd2, 32'h8000100C, 32'h0, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    data_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk1("rr_in_rdata", rready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk1("rr_arvalid", arvalid, 1'b0);
    chk1("rr_rready", rready, 1'b0);
    chk1("rr_awvalid", awvalid, 1'b0);
    chk1("rr_wvalid", wvalid, 1'b0);
    chk1("rr_bready", bready, 1'b0);
    chk("rr_rdata", rdata, 32'h0);
    seen = data_data_ok;
    repeat (6) begin
      @(negedge clk);
      if (data_data_ok) seen = 1;
    end
    chk1("rr_no_dok", seen, 1'b0);
    k_r = 0;

    // Randomized traffic with random slave waits.
    rand_mode = 1;
    fork
      inst_drv(60);
      data_drv(80);
    join
    wait_idle("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
